// File: rtl/axis_unpad_receiver.sv
// axis_unpad_receiver: strips edge pad units from AXI-Stream beats, checks the pads and counts frame length
module axis_unpad_receiver #(
   parameter int UNITS = 8,
   parameter int GROUPS = 2,
   parameter int WORD_WIDTH = 8,
   parameter int KERNEL_H_MAX = 3,
   parameter int BEAT_CNT_WIDTH = 16,
   localparam int P = KERNEL_H_MAX / 2,
   localparam int UE = UNITS + 2 * P,
   localparam int NI = 2 * GROUPS * UE,
   localparam int NO = 2 * GROUPS * UNITS
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   input  logic [NI*WORD_WIDTH-1:0]  s_axis_tdata,
   input  logic [NI-1:0]             s_axis_tkeep,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [NO*WORD_WIDTH-1:0]  m_axis_tdata,
   output logic [NO-1:0]             m_axis_tkeep,
   output logic                      frame_done,
   output logic [BEAT_CNT_WIDTH-1:0] frame_beats,
   output logic                      pad_error,
   input  logic                      err_clear
);
   localparam int BW = NO * WORD_WIDTH + NO + 1;

   logic [NO*WORD_WIDTH-1:0]  strip_data;
   logic [NO-1:0]             strip_keep;
   logic [BW-1:0]             in_beat, d0, d1;
   logic                      v0, v1, nv0, nv1, accept, pop, bad;
   logic [BEAT_CNT_WIDTH-1:0] cnt, cnt_inc;

   for (genvar c = 0; c < 2; c++) begin : g_c
      for (genvar g = 0; g < GROUPS; g++) begin : g_g
         for (genvar u = 0; u < UNITS; u++) begin : g_u
            assign strip_data[((c*GROUPS+g)*UNITS+u)*WORD_WIDTH +: WORD_WIDTH] =
               s_axis_tdata[((c*GROUPS+g)*UE+u+P)*WORD_WIDTH +: WORD_WIDTH];
            assign strip_keep[(c*GROUPS+g)*UNITS+u] = s_axis_tkeep[(c*GROUPS+g)*UE+u+P];
         end
      end
   end

   assign in_beat = {s_axis_tlast, strip_keep, strip_data};
   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = d0;
   assign m_axis_tvalid = v0;
   assign accept = s_axis_tvalid & s_axis_tready;
   assign pop = v0 & m_axis_tready;
   assign nv0 = pop ? (v1 | accept) : (v0 | accept);
   assign nv1 = pop ? (v1 & accept) : (v1 | (v0 & accept));
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

   // pad words must be zero and carry the keep of the first real unit of their group
   always_comb begin
      bad = 1'b0;
      for (int cc = 0; cc < 2; cc++)
         for (int gg = 0; gg < GROUPS; gg++)
            for (int i = 0; i < P; i++)
               bad = bad
                  | (s_axis_tdata[((cc*GROUPS+gg)*UE+i)*WORD_WIDTH +: WORD_WIDTH] != '0)
                  | (s_axis_tdata[((cc*GROUPS+gg)*UE+UE-1-i)*WORD_WIDTH +: WORD_WIDTH] != '0)
                  | (s_axis_tkeep[(cc*GROUPS+gg)*UE+i] != s_axis_tkeep[(cc*GROUPS+gg)*UE+P])
                  | (s_axis_tkeep[(cc*GROUPS+gg)*UE+UE-1-i] != s_axis_tkeep[(cc*GROUPS+gg)*UE+P]);
   end

   // two-entry skid buffer; d0 is the head presented on the master side
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         d0 <= '0;
         d1 <= '0;
         s_axis_tready <= 1'b0;
      end else begin
         v0 <= nv0;
         v1 <= nv1;
         s_axis_tready <= !(nv0 && nv1);
         if (pop && v1) d0 <= d1;
         else if (accept && (pop || !v0)) d0 <= in_beat;
         if (accept && (pop ? v1 : v0)) d1 <= in_beat;
      end
   end

   // sticky pad error; a new failure wins over a simultaneous clear
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) pad_error <= 1'b0;
      else if (accept && bad) pad_error <= 1'b1;
      else if (err_clear) pad_error <= 1'b0;
   end

   // saturating beat counter, latched into frame_beats on the last handshake of a frame
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt <= '0;
         frame_beats <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop & m_axis_tlast;
         if (pop) begin
            cnt <= m_axis_tlast ? '0 : cnt_inc;
            if (m_axis_tlast) frame_beats <= cnt_inc;
         end
      end
   end
endmodule
